bram_write_feeder: RTL and testbench

//  Upstream stage of the dual-port frame buffer. Accepts a byte stream on a

---
 rtl/bram_write_feeder.sv | 158 +++++++++++++++
 tb/tb_bram_write_feeder.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_write_feeder.sv
// bram_write_feeder: byte-stream to BRAM write-port feeder.
// Accepts bytes on a valid/ready handshake, buffers them in a small FIFO and
// writes them to sequential addresses starting at 0. Signals frame completion
// once FRAME_LEN bytes have been written.
// Optional feature: define FEEDER_BYPASS_EN to let a byte skip the empty FIFO
// and reach the write port one edge after acceptance instead of two.
module bram_write_feeder #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned ADDR_W    = 11,
  parameter int unsigned FRAME_LEN = 2048
) (
  input  logic              clk1,
  input  logic              reset,
  input  logic              start,
  input  logic              din_valid,
  input  logic [7:0]        din,
  output logic              din_ready,
  output logic              ena,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [7:0]        dina,
  output logic              busy,
  output logic              frame_done
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned PW    = PTR_W + 1;
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN);

`ifdef FEEDER_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;

  state_t            state;
  state_t            state_nxt;

  logic [7:0]        mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CNT_W-1:0]  accepted;
  logic [CNT_W-1:0]  written;

  logic              fifo_empty;
  logic              fifo_full;
  logic              hs;
  logic              bypass;
  logic              fifo_push;
  logic              fifo_pop;
  logic              wr_any;
  logic [7:0]        wr_data;
  logic              last_wr;

  // FIFO occupancy flags from the wrap-bit pointer pair
  always_comb begin
    fifo_empty = (wr_ptr == rd_ptr);
    fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  end

  // State register
  always_ff @(posedge clk1 or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: the final write moves to DONE, DONE lasts one cycle
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_FILL;
      S_FILL:  if (last_wr) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Handshake, FIFO control and write selection decoded from state
  always_comb begin
    din_ready = 1'b0;
    hs        = 1'b0;
    bypass    = 1'b0;
    fifo_push = 1'b0;
    fifo_pop  = 1'b0;
    if (state == S_FILL) begin
      din_ready = !fifo_full && (accepted < LAST);
      hs        = din_valid && din_ready;
      bypass    = BYPASS && fifo_empty && hs;
      fifo_push = hs && !bypass;
      fifo_pop  = !fifo_empty;
    end
    wr_any  = fifo_pop || bypass;
    wr_data = fifo_pop ? mem[rd_ptr[PTR_W-1:0]] : din;
    last_wr = wr_any && (written == (LAST - CNT_W'(1)));
  end

  // FIFO storage; no reset needed, validity is tracked by the pointers
  always_ff @(posedge clk1) begin
    if (fifo_push) mem[wr_ptr[PTR_W-1:0]] <= din;
  end

  // Pointers, counters and registered write-port / status outputs
  always_ff @(posedge clk1 or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      accepted   <= '0;
      written    <= '0;
      ena        <= 1'b0;
      addra      <= '0;
      dina       <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          ena <= 1'b0;
          if (start) begin
            busy     <= 1'b1;
            addra    <= '0;
            accepted <= '0;
            written  <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
          end
        end
        S_FILL: begin
          if (fifo_push) wr_ptr <= wr_ptr + PW'(1);
          if (fifo_pop)  rd_ptr <= rd_ptr + PW'(1);
          if (hs)        accepted <= accepted + CNT_W'(1);
          if (wr_any) begin
            ena     <= 1'b1;
            dina    <= wr_data;
            addra   <= written[ADDR_W-1:0];
            written <= written + CNT_W'(1);
          end else begin
            ena <= 1'b0;
          end
        end
        S_DONE: begin
          ena        <= 1'b0;
          busy       <= 1'b0;
          frame_done <= 1'b1;
        end
        default: ena <= 1'b0;
      endcase
    end
  end

  // Write strobe mirrors the enable
  assign wea = ena;

endmodule

// File: tb/tb_bram_write_feeder.sv
// Directed bench for bram_write_feeder using three differently sized instances.
module tb_bram_write_feeder;

`ifdef FEEDER_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   failed = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A: DEPTH 8, 11-bit address, 4-byte frame
  logic start_a = 0, valid_a = 0, ready_a, ena_a, wea_a, busy_a, done_a;
  logic [7:0] din_a = 0, dina_a;
  logic [10:0] addra_a;
  // Instance B: DEPTH 4, 4-bit address, 16-byte frame
  logic start_b = 0, valid_b = 0, ready_b, ena_b, wea_b, busy_b, done_b;
  logic [7:0] din_b = 0, dina_b;
  logic [3:0] addra_b;
  // Instance C: DEPTH 4, 3-bit address, 8-byte frame
  logic start_c = 0, valid_c = 0, ready_c, ena_c, wea_c, busy_c, done_c;
  logic [7:0] din_c = 0, dina_c;
  logic [2:0] addra_c;

  bram_write_feeder #(.DEPTH(8), .ADDR_W(11), .FRAME_LEN(4)) u_a (
    .clk1(clk), .reset(rst_n), .start(start_a), .din_valid(valid_a), .din(din_a),
    .din_ready(ready_a), .ena(ena_a), .wea(wea_a), .addra(addra_a), .dina(dina_a),
    .busy(busy_a), .frame_done(done_a));
  bram_write_feeder #(.DEPTH(4), .ADDR_W(4), .FRAME_LEN(16)) u_b (
    .clk1(clk), .reset(rst_n), .start(start_b), .din_valid(valid_b), .din(din_b),
    .din_ready(ready_b), .ena(ena_b), .wea(wea_b), .addra(addra_b), .dina(dina_b),
    .busy(busy_b), .frame_done(done_b));
  bram_write_feeder #(.DEPTH(4), .ADDR_W(3), .FRAME_LEN(8)) u_c (
    .clk1(clk), .reset(rst_n), .start(start_c), .din_valid(valid_c), .din(din_c),
    .din_ready(ready_c), .ena(ena_c), .wea(wea_c), .addra(addra_c), .dina(dina_c),
    .busy(busy_c), .frame_done(done_c));

  // Observed writes, acceptance cycles and frame_done cycles per instance
  int wa_a[$], wc_a[$], ac_a[$], dn_a[$];
  logic [7:0] wd_a[$];
  int wa_b[$], dn_b[$];
  logic [7:0] wd_b[$];
  int wa_c[$], dn_c[$];
  logic [7:0] wd_c[$];

  always @(posedge clk) if (valid_a && ready_a) ac_a.push_back(cyc);
  always @(negedge clk) begin
    if (ena_a) begin wa_a.push_back(int'(addra_a)); wd_a.push_back(dina_a); wc_a.push_back(cyc); end
    if (done_a) dn_a.push_back(cyc);
    if (ena_b) begin wa_b.push_back(int'(addra_b)); wd_b.push_back(dina_b); end
    if (done_b) dn_b.push_back(cyc);
    if (ena_c) begin wa_c.push_back(int'(addra_c)); wd_c.push_back(dina_c); end
    if (done_c) dn_c.push_back(cyc);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_a();
    wa_a.delete(); wd_a.delete(); wc_a.delete(); ac_a.delete(); dn_a.delete();
  endtask

  task automatic send_a(input logic [7:0] b);
    valid_a = 1'b1;
    din_a   = b;
    for (int t = 0; t < 20 && !ready_a; t++) tick();
    if (!ready_a) begin
      tests++; failed++;
      $display("FAIL send_a timeout: din_ready=%b required 1", ready_a);
    end
    tick();
    valid_a = 1'b0;
  endtask

  task automatic send_c(input logic [7:0] b);
    valid_c = 1'b1;
    din_c   = b;
    for (int t = 0; t < 20 && !ready_c; t++) tick();
    if (!ready_c) begin
      tests++; failed++;
      $display("FAIL send_c timeout: din_ready=%b required 1", ready_c);
    end
    tick();
    valid_c = 1'b0;
  endtask

  task automatic wait_done_a();
    for (int t = 0; t < 30 && dn_a.size() == 0; t++) tick();
    repeat (3) tick();
  endtask

  task automatic test_reset();
    tests++;
    if ({ready_a, ena_a, wea_a, busy_a, done_a} !== 5'b0 || addra_a !== 11'd0 || dina_a !== 8'd0) begin
      failed++;
      $display("FAIL reset_state: rdy=%b ena=%b wea=%b busy=%b done=%b addr=%0d data=%h required all 0",
               ready_a, ena_a, wea_a, busy_a, done_a, addra_a, dina_a);
    end
    start_a = 1'b1; tick(); start_a = 1'b0;
    send_a(8'h55); send_a(8'h66); tick(); tick();
    tests++;
    if (ena_a !== 1'b0 || addra_a !== 11'd1 || dina_a !== 8'h66) begin
      failed++;
      $display("FAIL pre_reset_write: ena=%b addr=%0d data=%h required 0/1/66", ena_a, addra_a, dina_a);
    end
    rst_n = 1'b0;
    #2;
    tests++;
    if ({ready_a, ena_a, wea_a, busy_a, done_a} !== 5'b0 || addra_a !== 11'd0 || dina_a !== 8'd0) begin
      failed++;
      $display("FAIL midrun_reset: rdy=%b ena=%b busy=%b addr=%0d data=%h required all 0",
               ready_a, ena_a, busy_a, addra_a, dina_a);
    end
    tick(); rst_n = 1'b1; tick();
    start_a = 1'b1; tick(); start_a = 1'b0;
    tests++;
    if (busy_a !== 1'b1 || ready_a !== 1'b1) begin
      failed++;
      $display("FAIL start_busy: busy=%b din_ready=%b required 1/1", busy_a, ready_a);
    end
  endtask

  task automatic test_frame4();
    logic [7:0] exp [4];
    exp[0] = 8'hA1; exp[1] = 8'hB2; exp[2] = 8'hC3; exp[3] = 8'hD4;
    clear_a();
    for (int i = 0; i < 4; i++) send_a(exp[i]);
    wait_done_a();
    tests++;
    if (wa_a.size() != 4 || ac_a.size() != 4) begin
      failed++;
      $display("FAIL frame4_count: writes=%0d accepts=%0d required 4/4", wa_a.size(), ac_a.size());
    end
    for (int i = 0; i < 4 && i < wa_a.size() && i < ac_a.size(); i++) begin
      tests++;
      if (wa_a[i] != i || wd_a[i] !== exp[i] || (wc_a[i] - ac_a[i]) != LAT) begin
        failed++;
        $display("FAIL frame4_write%0d: addr=%0d data=%h lat=%0d required %0d/%h/%0d",
                 i, wa_a[i], wd_a[i], wc_a[i] - ac_a[i], i, exp[i], LAT);
      end
    end
    tests++;
    if (dn_a.size() != 1 || busy_a !== 1'b0) begin
      failed++;
      $display("FAIL frame4_done: pulses=%0d busy=%b required 1/0", dn_a.size(), busy_a);
    end
  endtask

  task automatic test_gapped();
    clear_a();
    start_a = 1'b1; tick(); start_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      valid_a = 1'b1; din_a = 8'h40 + 8'(i);
      tick();
      valid_a = 1'b0;
      tick();
      tick();
      tests++;
      if (ena_a !== 1'b0 || wea_a !== 1'b0 || addra_a !== 11'(i) || dina_a !== 8'h40 + 8'(i)) begin
        failed++;
        $display("FAIL gap_hold%0d: ena=%b wea=%b addr=%0d data=%h required 0/0/%0d/%h",
                 i, ena_a, wea_a, addra_a, dina_a, i, 8'h40 + 8'(i));
      end
    end
    wait_done_a();
    tests++;
    if (wa_a.size() != 4 || dn_a.size() != 1) begin
      failed++;
      $display("FAIL gap_pulses: ena_cycles=%0d done_pulses=%0d required 4/1", wa_a.size(), dn_a.size());
    end else begin
      tests++;
      if (dn_a[0] != wc_a[3] + 1) begin
        failed++;
        $display("FAIL gap_done_timing: done_cyc=%0d required %0d", dn_a[0], wc_a[3] + 1);
      end
    end
  endtask

  task automatic test_start_ignored();
    clear_a();
    start_a = 1'b1; tick(); start_a = 1'b0;
    send_a(8'h31); send_a(8'h32);
    start_a = 1'b1; tick(); start_a = 1'b0;
    send_a(8'h33); send_a(8'h34);
    valid_a = 1'b1; din_a = 8'hEE;
    for (int t = 0; t < 4; t++) begin
      tests++;
      if (ready_a !== 1'b0) begin
        failed++;
        $display("FAIL post_frame_ready%0d: din_ready=%b required 0", t, ready_a);
      end
      tick();
    end
    valid_a = 1'b0;
    wait_done_a();
    tests++;
    if (wa_a.size() != 4 || dn_a.size() != 1) begin
      failed++;
      $display("FAIL start_ign_count: writes=%0d done=%0d required 4/1", wa_a.size(), dn_a.size());
    end
    for (int i = 0; i < 4 && i < wa_a.size(); i++) begin
      tests++;
      if (wa_a[i] != i || wd_a[i] !== 8'h31 + 8'(i)) begin
        failed++;
        $display("FAIL start_ign_write%0d: addr=%0d data=%h required %0d/%h", i, wa_a[i], wd_a[i], i, 8'h31 + 8'(i));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic hs;
    wa_b.delete(); wd_b.delete(); dn_b.delete();
    start_b = 1'b1; tick(); start_b = 1'b0;
    valid_b = 1'b1; din_b = 8'h00;
    for (int t = 0; t < 100 && din_b != 8'd16; t++) begin
      hs = ready_b;
      tick();
      if (hs) din_b = din_b + 8'd1;
    end
    for (int t = 0; t < 3; t++) begin
      tests++;
      if (ready_b !== 1'b0) begin
        failed++;
        $display("FAIL b2b_ready_after%0d: din_ready=%b required 0", t, ready_b);
      end
      tick();
    end
    valid_b = 1'b0;
    for (int t = 0; t < 30 && dn_b.size() == 0; t++) tick();
    repeat (3) tick();
    tests++;
    if (wa_b.size() != 16 || dn_b.size() != 1 || addra_b !== 4'hF) begin
      failed++;
      $display("FAIL b2b_count: writes=%0d done=%0d last_addr=%0d required 16/1/15",
               wa_b.size(), dn_b.size(), addra_b);
    end
    for (int i = 0; i < 16 && i < wa_b.size(); i++) begin
      tests++;
      if (wa_b[i] != i || wd_b[i] !== 8'(i)) begin
        failed++;
        $display("FAIL b2b_write%0d: addr=%0d data=%h required %0d/%h", i, wa_b[i], wd_b[i], i, 8'(i));
      end
    end
  endtask

  task automatic test_reset_midframe();
    wa_c.delete(); wd_c.delete(); dn_c.delete();
    start_c = 1'b1; tick(); start_c = 1'b0;
    for (int i = 0; i < 5; i++) send_c(8'h10 + 8'(i));
    tests++;
    if (ena_c !== 1'b1) begin
      failed++;
      $display("FAIL midframe_pre: ena=%b required 1", ena_c);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (ena_c !== 1'b0 || addra_c !== 3'd0 || busy_c !== 1'b0) begin
      failed++;
      $display("FAIL midframe_reset: ena=%b addr=%0d busy=%b required 0/0/0", ena_c, addra_c, busy_c);
    end
    tick(); rst_n = 1'b1; tick();
    wa_c.delete(); wd_c.delete(); dn_c.delete();
    start_c = 1'b1; tick(); start_c = 1'b0;
    for (int i = 0; i < 8; i++) send_c(8'h20 + 8'(i));
    for (int t = 0; t < 30 && dn_c.size() == 0; t++) tick();
    repeat (3) tick();
    tests++;
    if (wa_c.size() != 8 || dn_c.size() != 1 || addra_c !== 3'h7) begin
      failed++;
      $display("FAIL refill_count: writes=%0d done=%0d last_addr=%0d required 8/1/7",
               wa_c.size(), dn_c.size(), addra_c);
    end
    for (int i = 0; i < 8 && i < wa_c.size(); i++) begin
      tests++;
      if (wa_c[i] != i || wd_c[i] !== 8'h20 + 8'(i)) begin
        failed++;
        $display("FAIL refill_write%0d: addr=%0d data=%h required %0d/%h", i, wa_c[i], wd_c[i], i, 8'h20 + 8'(i));
      end
    end
  endtask

  initial begin
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    test_reset();
    test_frame4();
    test_gapped();
    test_start_ignored();
    test_back_to_back();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
